// File: rtl/regfile_mp_if.sv
// Register file access bundle: decode-side read addresses/data and the
// writeback-side write port, plus clear-status flags.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rs_addr;
  logic [NUM_RD*DATA_W-1:0] rs_data;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_wren;
  logic                     busy;
  logic                     wr_drop;

  modport master (
    output rs_addr, rd_addr, rd_data, rd_wren,
    input  rs_data, busy, wr_drop
  );

  modport slave (
    input  rs_addr, rd_addr, rd_data, rd_wren,
    output rs_data, busy, wr_drop
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardware clear sequence.
// Optional feature: define REGFILE_BYPASS_EN to forward the write port to
// any read port addressing the same entry in the same cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | zeroing entry clr_ptr each edge; reads return 0, writes dropped
// S_IDLE  | normal operation
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic         i_clk,
  input logic         i_reset,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  // Pointer is one bit wider than the address so it never wraps before the compare.
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     clr_ptr_q, clr_ptr_d;
  logic                wr_drop_q, wr_drop_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                usr_wr_ok;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   raddr;
  logic [DATA_W-1:0]   rval;
  logic [NUM_RD*DATA_W-1:0] rs_data_c;

  // Entry 0 is read-only when it is hardwired to zero.
  assign usr_wr_ok = bus.rd_wren && !((ZERO_REG != 0) && (bus.rd_addr == '0));

  // State, clear pointer and drop flag registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Next-state logic and selection of the single array write per cycle.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.rd_addr;
    mem_wdata = bus.rd_data;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q[ADDR_W-1:0];
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        wr_drop_d = bus.rd_wren;
        if (clr_ptr_q == LAST_PTR) state_d = S_IDLE;
      end
      S_IDLE: begin
        mem_we = usr_wr_ok;
      end
      default: begin
        state_d   = S_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Array write port; a write coinciding with reset is discarded.
  always_ff @(posedge i_clk) begin
    if (!i_reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Combinational read ports, forced to zero while clearing.
  always_comb begin
    rs_data_c = '0;
    raddr     = '0;
    rval      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      raddr = bus.rs_addr[k*ADDR_W +: ADDR_W];
      rval  = mem[raddr];
`ifdef REGFILE_BYPASS_EN
      if (bus.rd_wren && (state_q == S_IDLE) && (raddr == bus.rd_addr)) rval = bus.rd_data;
`else
`endif
      if ((ZERO_REG != 0) && (raddr == '0)) rval = '0;
      if (state_q != S_IDLE) rval = '0;
      rs_data_c[k*DATA_W +: DATA_W] = rval;
    end
  end

  assign bus.rs_data = rs_data_c;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default build (32x32, 2 ports, x0 = 0)
// and a 16x64, 3-port, no-zero-register instance.
module tb_regfile_mp;
  logic i_clk;
  logic rst_a;
  logic rst_b;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
  regfile_mp_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3)) bus_b ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .i_clk(i_clk), .i_reset(rst_a), .bus(bus_a.slave));
  regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0)) dut_b (
    .i_clk(i_clk), .i_reset(rst_b), .bus(bus_b.slave));

  // Source codes: 0/1 = A port data, 2 = A busy, 3 = A drop,
  // 10..12 = B port data, 13 = B busy.
  string       name_q[$];
  int          src_q[$];
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] SAME_CYC_EXP = 32'h2;
`else
  localparam logic [31:0] SAME_CYC_EXP = 32'h1;
`endif

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input int src, input logic [63:0] v);
    name_q.push_back(nm);
    src_q.push_back(src);
    exp_q.push_back(v);
  endtask

  task automatic busy_walk(input string nm, input int src, input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      expect_v(nm, src, (i < n) ? 64'd1 : 64'd0);
    end
  endtask

  // Monitor: drains the scoreboard at each falling edge.
  initial begin
    string       nm;
    int          src;
    logic [63:0] ex;
    logic [63:0] act;
    forever begin
      @(negedge i_clk);
      while (src_q.size() > 0) begin
        nm  = name_q.pop_front();
        src = src_q.pop_front();
        ex  = exp_q.pop_front();
        case (src)
          0, 1:       act = {32'h0, bus_a.rs_data[src*32 +: 32]};
          2:          act = {63'h0, bus_a.busy};
          3:          act = {63'h0, bus_a.wr_drop};
          10, 11, 12: act = bus_b.rs_data[(src-10)*64 +: 64];
          13:         act = {63'h0, bus_b.busy};
          default:    act = 64'hx;
        endcase
        n_checks++;
        if (act !== ex) begin
          n_fail++;
          $display("FAIL %s src=%0d actual=%h required=%h", nm, src, act, ex);
        end
      end
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.rs_addr = '0; bus_a.rd_addr = '0; bus_a.rd_data = '0; bus_a.rd_wren = 1'b0;
    bus_b.rs_addr = '0; bus_b.rd_addr = '0; bus_b.rd_data = '0; bus_b.rd_wren = 1'b0;

    // Reset held 3 edges, then the 32-edge clear.
    bus_a.rs_addr = {5'd0, 5'd5};
    tick();
    expect_v("rst_busy", 2, 64'd1);
    expect_v("rst_drop", 3, 64'd0);
    expect_v("rst_rdata", 0, 64'd0);
    expect_v("rst_busy_b", 13, 64'd1);
    tick();
    tick();
    rst_a = 1'b0;
    busy_walk("clear_busy", 2, 32);
    for (int i = 0; i < 32; i++) begin
      bus_a.rs_addr = {5'(31 - i), 5'(i)};
      expect_v("clear_rd0", 0, 64'd0);
      expect_v("clear_rd1", 1, 64'd0);
      tick();
    end

    // Write then read on both ports.
    bus_a.rd_addr = 5'd5; bus_a.rd_data = 32'hDEAD_BEEF; bus_a.rd_wren = 1'b1;
    tick();
    bus_a.rd_wren = 1'b0;
    bus_a.rs_addr = {5'd5, 5'd5};
    expect_v("wr_rd_p0", 0, 64'hDEAD_BEEF);
    expect_v("wr_rd_p1", 1, 64'hDEAD_BEEF);
    expect_v("wr_nodrop", 3, 64'd0);
    tick();

    // Hardwired x0.
    bus_a.rd_addr = 5'd0; bus_a.rd_data = 32'h1234_5678; bus_a.rd_wren = 1'b1;
    tick();
    bus_a.rd_wren = 1'b0;
    bus_a.rs_addr = {5'd5, 5'd0};
    expect_v("x0_read", 0, 64'd0);
    expect_v("x5_keep", 1, 64'hDEAD_BEEF);
    expect_v("x0_nodrop", 3, 64'd0);
    tick();

    // Same-cycle read and write of x7.
    bus_a.rd_addr = 5'd7; bus_a.rd_data = 32'h1; bus_a.rd_wren = 1'b1;
    tick();
    bus_a.rd_data = 32'h2;
    bus_a.rs_addr = {5'd7, 5'd5};
    expect_v("same_cyc_p1", 1, {32'h0, SAME_CYC_EXP});
    tick();
    bus_a.rd_wren = 1'b0;
    bus_a.rs_addr = {5'd7, 5'd7};
    expect_v("next_cyc_p0", 0, 64'h2);
    expect_v("next_cyc_p1", 1, 64'h2);
    tick();

    // Dropped write at clear cycle 10, reset again at clear cycle 20.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      expect_v("drop_busy", 2, 64'd1);
      expect_v("drop_pulse", 3, (k == 10) ? 64'd1 : 64'd0);
      if (k == 9) begin
        bus_a.rd_addr = 5'd3; bus_a.rd_data = 32'hAAAA_AAAA; bus_a.rd_wren = 1'b1;
      end
      if (k == 10) bus_a.rd_wren = 1'b0;
    end
    rst_a = 1'b1;
    bus_a.rd_wren = 1'b1;
    tick();
    bus_a.rd_wren = 1'b0;
    rst_a = 1'b0;
    expect_v("rst_mid_busy", 2, 64'd1);
    expect_v("rst_mid_nodrop", 3, 64'd0);
    busy_walk("reclear_busy", 2, 32);
    bus_a.rs_addr = {5'd5, 5'd3};
    expect_v("x3_cleared", 0, 64'd0);
    expect_v("x5_cleared", 1, 64'd0);
    tick();

    // 64-bit, 16-entry, 3-port instance without a zero register.
    rst_b = 1'b0;
    busy_walk("b_clear_busy", 13, 16);
    bus_b.rd_addr = 4'd0; bus_b.rd_data = 64'hFFFF_FFFF_0000_0001; bus_b.rd_wren = 1'b1;
    tick();
    bus_b.rd_wren = 1'b0;
    bus_b.rs_addr = {4'd0, 4'd0, 4'd0};
    expect_v("b_e0_p0", 10, 64'hFFFF_FFFF_0000_0001);
    expect_v("b_e0_p1", 11, 64'hFFFF_FFFF_0000_0001);
    expect_v("b_e0_p2", 12, 64'hFFFF_FFFF_0000_0001);
    tick();
    bus_b.rd_addr = 4'd15; bus_b.rd_data = 64'h0000_0000_0000_0055; bus_b.rd_wren = 1'b1;
    tick();
    bus_b.rd_wren = 1'b0;
    bus_b.rs_addr = {4'd0, 4'd15, 4'd0};
    expect_v("b_e0_kept", 10, 64'hFFFF_FFFF_0000_0001);
    expect_v("b_e15", 11, 64'h55);
    expect_v("b_e0_kept2", 12, 64'hFFFF_FFFF_0000_0001);
    tick();

    tick();
    tick();
    if (src_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", src_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
